// File: rtl/disp_pkg.sv
// Shared definitions for the display-chain arbiter: FSM encoding, default
// geometry and a counter-width helper.
package disp_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int CLK_DIV_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_LATCH    = 3'd4,
        ST_ACK      = 3'd5
    } disp_state_e;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/disp_div_tick.sv
// Modulo-CLK_DIV cycle counter with synchronous clear; tick marks the last
// cycle of each CLK_DIV-cycle phase while enabled.
module disp_div_tick
    import disp_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CNT_W = cnt_w(CLK_DIV);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == TERM);

    // Next count: clear wins, wrap at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == TERM) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/disp_chain_arbiter.sv
// Two-requester arbiter driving one 74HC595 chain (ds/shcp/stcp/oe).
// Build option DISP_ARB_ROUND_ROBIN_EN: ties go to the requester not served last.
module disp_chain_arbiter
    import disp_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    input  logic              sel,
    output logic              ds,
    output logic              shcp,
    output logic              stcp,
    output logic              oe,
    output logic              busy,
    output logic              grant
);

    localparam int IDX_W = cnt_w(DATA_W);

    disp_state_e       state_q, state_d;
    logic [DATA_W-1:0] frame_q, frame_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              gnt_q, gnt_d;
    logic              ds_q, ds_d;
    logic              shcp_q, shcp_d;
    logic              stcp_q, stcp_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              tie_gnt_s;
    logic              div_en_s;
    logic              tick_s;

`ifdef DISP_ARB_ROUND_ROBIN_EN
    logic unused_sel_s;
    assign unused_sel_s = sel;
    assign tie_gnt_s    = ~gnt_q;
`else
    assign tie_gnt_s    = sel;
`endif

    assign div_en_s = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI) ||
                      (state_q == ST_LATCH);

    disp_div_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (~div_en_s),
        .en_i   (div_en_s),
        .tick_o (tick_s)
    );

    // Next-state, frame shifter and bit index.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    gnt_d   = tie_gnt_s;
                    state_d = ST_LOAD;
                end else if (req0) begin
                    gnt_d   = 1'b0;
                    state_d = ST_LOAD;
                end else if (req1) begin
                    gnt_d   = 1'b1;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (gnt_q) begin
                    frame_d = data1;
                end else begin
                    frame_d = data0;
                end
                idx_d   = IDX_W'(DATA_W - 1);
                state_d = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                if (tick_s) begin
                    state_d = ST_SHIFT_HI;
                end else begin
                    state_d = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_HI: begin
                if (!tick_s) begin
                    state_d = ST_SHIFT_HI;
                end else if (idx_q == '0) begin
                    state_d = ST_LATCH;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                    frame_d = {frame_q[DATA_W-2:0], 1'b0};
                    state_d = ST_SHIFT_LO;
                end
            end
            ST_LATCH: begin
                if (tick_s) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_LATCH;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin values follow the state being entered so every output is a flop.
    always_comb begin
        ds_d   = ds_q;
        oe_d   = oe_q;
        shcp_d = (state_d == ST_SHIFT_HI);
        stcp_d = (state_d == ST_LATCH);
        busy_d = (state_d != ST_IDLE);
        ack0_d = (state_d == ST_ACK) && !gnt_d;
        ack1_d = (state_d == ST_ACK) && gnt_d;
        if ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) begin
            ds_d = frame_d[DATA_W-1];
        end else begin
            ds_d = ds_q;
        end
        if ((state_q == ST_LATCH) && (state_d == ST_ACK)) begin
            oe_d = 1'b0;
        end else begin
            oe_d = oe_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            idx_q   <= '0;
            gnt_q   <= 1'b0;
            ds_q    <= 1'b0;
            shcp_q  <= 1'b0;
            stcp_q  <= 1'b0;
            oe_q    <= 1'b1;
            busy_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            ds_q    <= ds_d;
            shcp_q  <= shcp_d;
            stcp_q  <= stcp_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    assign ds    = ds_q;
    assign shcp  = shcp_q;
    assign stcp  = stcp_q;
    assign oe    = oe_q;
    assign busy  = busy_q;
    assign grant = gnt_q;
    assign ack0  = ack0_q;
    assign ack1  = ack1_q;

endmodule

// File: tb/tb_disp_chain_arbiter.sv
// Self-checking bench for disp_chain_arbiter: table vectors, corner sequences
// and randomized requests against an arbitration/serial-frame reference model.
module tb_disp_chain_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1, sel;
    logic [15:0] data0, data1;
    logic        ack0, ack1, ds, shcp, stcp, oe, busy, grant;

    int n_checks = 0;
    int n_fail   = 0;
    int last_who = 0;

    disp_chain_arbiter #(.DATA_W(16), .CLK_DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .data0 (data0),
        .ack0  (ack0),
        .req1  (req1),
        .data1 (data1),
        .ack1  (ack1),
        .sel   (sel),
        .ds    (ds),
        .shcp  (shcp),
        .stcp  (stcp),
        .oe    (oe),
        .busy  (busy),
        .grant (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          r0;
        bit          r1;
        bit          s;
        logic [15:0] d0;
        logic [15:0] d1;
        int          who;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference arbitration rule.
    function automatic int pick(input bit r0, input bit r1, input bit s, input int last);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
`ifdef DISP_ARB_ROUND_ROBIN_EN
        return (last == 0) ? 1 : 0;
`else
        return s ? 1 : 0;
`endif
    endfunction

    // Watches one transfer starting just after the granting edge.
    // kind 0: plain, 1: overwrite data0 after LOAD, 2: reset at 60th shift cycle.
    task automatic observe(input int who, input logic [15:0] frame, input int kind, input bit hold);
        int c, nbits, st_rise, st_w, ack_c, other_ack;
        logic [15:0] cap;
        logic ps, pst;
        bit done;
        c = 0; nbits = 0; st_rise = 0; st_w = 0; ack_c = -1; other_ack = 0;
        cap = 16'h0000; ps = 1'b0; pst = 1'b0; done = 1'b0;
        while (!done && c < 300) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                chk("busy_at_load", 32'(busy), 32'd1);
                chk("grant", 32'(grant), 32'(who));
            end
            if (shcp && !ps) begin
                cap = {cap[14:0], ds};
                nbits++;
            end
            if (stcp && !pst) st_rise++;
            if (stcp) st_w++;
            ps = shcp;
            pst = stcp;
            if ((who == 0) ? ack1 : ack0) other_ack++;
            if ((who == 0) ? ack0 : ack1) begin
                ack_c = c;
                done = 1'b1;
            end
            if (kind == 1 && c == 2) data0 = 16'hFFFF;
            if (kind == 2 && c == 61) rst = 1'b0;
            if (kind == 2 && c == 62) begin
                chk("abort_outputs", 32'({ds, shcp, stcp, oe, busy, ack0, ack1, grant}),
                    32'(8'b0001_0000));
                chk("abort_no_stcp", 32'(st_rise), 32'd0);
                chk("abort_no_ack", 32'(other_ack + ((ack_c >= 0) ? 1 : 0)), 32'd0);
                rst = 1'b1;
                return;
            end
        end
        if (!done) chk("ack_timeout", 32'd0, 32'd1);
        chk("ack_latency", 32'(ack_c), 32'd134);
        chk("bit_count", 32'(nbits), 32'd16);
        chk("frame_bits", 32'(cap), 32'(frame));
        chk("stcp_pulses", 32'(st_rise), 32'd1);
        chk("stcp_width", 32'(st_w), 32'd4);
        chk("other_ack", 32'(other_ack), 32'd0);
        chk("oe_enabled", 32'(oe), 32'd0);
        if (!hold) begin
            if (who == 0) req0 = 1'b0;
            else req1 = 1'b0;
        end
    endtask

    task automatic do_xfer(input int who, input logic [15:0] frame, input int kind, input bit hold);
        @(posedge clk);
        observe(who, frame, kind, hold);
        last_who = who;
    endtask

    // The one IDLE cycle between frames: ack already gone, busy low.
    task automatic idle_gap();
        @(negedge clk);
        chk("gap_busy", 32'(busy), 32'd0);
        chk("gap_ack", 32'({ack0, ack1}), 32'd0);
    endtask

    vec_t tbl[6];

    initial begin
        int w;
        bit p0, p1;
        logic [15:0] d_hold;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 16'hA5C3, 16'h0000, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 16'h1234, 16'h8001, 1};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 16'h0F0F, 16'hF0F0, 1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 16'h5555, 16'hAAAA, 0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 16'h0001, 16'h8000, 1};

        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; sel = 1'b0;
        data0 = 16'h0000; data1 = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_reset_state", 32'({oe, shcp, stcp, ds, busy, ack0, ack1, grant}),
                32'(8'b1000_0000));
        end

        // Table vectors, each from IDLE with all requests withdrawn afterwards.
        for (int i = 0; i < 6; i++) begin
            req0 = tbl[i].r0; req1 = tbl[i].r1; sel = tbl[i].s;
            data0 = tbl[i].d0; data1 = tbl[i].d1;
`ifdef DISP_ARB_ROUND_ROBIN_EN
            w = pick(tbl[i].r0, tbl[i].r1, tbl[i].s, last_who);
`else
            w = tbl[i].who;
`endif
            do_xfer(w, (w == 1) ? tbl[i].d1 : tbl[i].d0, 0, 1'b0);
            req0 = 1'b0; req1 = 1'b0;
            idle_gap();
        end

        // Simultaneous requests: winner first, loser after one IDLE cycle.
        req0 = 1'b1; req1 = 1'b1; sel = 1'b1;
        data0 = 16'h0C0C; data1 = 16'hB00B;
        w = pick(1'b1, 1'b1, 1'b1, last_who);
        do_xfer(w, (w == 1) ? 16'hB00B : 16'h0C0C, 0, 1'b0);
        sel = 1'b0;
        idle_gap();
        do_xfer(1 - w, (w == 1) ? 16'h0C0C : 16'hB00B, 0, 1'b0);
        idle_gap();

        // Frame is frozen once loaded.
        req0 = 1'b1; data0 = 16'h6B2D;
        do_xfer(0, 16'h6B2D, 1, 1'b0);
        idle_gap();

        // Reset mid-shift, then a normal transfer with the same request.
        req0 = 1'b1; data0 = 16'h3C96;
        do_xfer(0, 16'h3C96, 2, 1'b0);
        last_who = 0;
        do_xfer(0, 16'h3C96, 0, 1'b0);
        idle_gap();

        // Held request: back-to-back frames every 135 cycles.
        req1 = 1'b1; d_hold = 16'hC3A5; data1 = d_hold;
        for (int k = 0; k < 3; k++) begin
            do_xfer(1, d_hold, 0, 1'b1);
            idle_gap();
        end
        req1 = 1'b0;
        idle_gap();

        // Random requests; a loser keeps requesting until served.
        p0 = 1'b0; p1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (!p0) p0 = 1'($urandom_range(0, 1));
            if (!p1) p1 = 1'($urandom_range(0, 1));
            if (!p0 && !p1) p0 = 1'b1;
            data0 = 16'($urandom); data1 = 16'($urandom);
            sel = 1'($urandom_range(0, 1));
            req0 = p0; req1 = p1;
            w = pick(p0, p1, sel, last_who);
            do_xfer(w, (w == 1) ? data1 : data0, 0, 1'b0);
            if (w == 1) p1 = 1'b0;
            else p0 = 1'b0;
            idle_gap();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_chain_arbiter.md
Name: disp_chain_arbiter

Overview:
Shares one 74HC595 display shift-register chain (ds/shcp/stcp/oe) between two frame requesters, e.g. clock 0 and clock 1 display engines. Each requester offers a parallel frame of segment and digit-select bits under a req/ack handshake. The block grants one requester, serialises the captured frame MSB-first, pulses the storage latch and acknowledges. It sits between the clock datapaths and the top-level display pins and replaces a pin-level mux.

Parameters:
DATA_W, 16, frame width in bits shifted per transfer
CLK_DIV, 4, system clock cycles per shcp half-period and per stcp high pulse (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
req0  in  1  requester 0 frame request; held until ack0
data0  in  DATA_W  requester 0 frame, sampled at grant
ack0  out  1  one-cycle done pulse to requester 0
req1  in  1  requester 1 frame request
data1  in  DATA_W  requester 1 frame
ack1  out  1  one-cycle done pulse to requester 1
sel  in  1  preferred requester on a tie (current display mode)
ds  out  1  serial data to chain
shcp  out  1  shift clock to chain
stcp  out  1  storage latch clock to chain
oe  out  1  chain output enable, active-low
busy  out  1  transfer in progress
grant  out  1  index of requester currently or last served

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst). All outputs registered.
- Reset values: ds=0, shcp=0, stcp=0, oe=1 (blanked), ack0=ack1=0, busy=0, grant=0; FSM to IDLE; divider and bit counter cleared.
- FSM: IDLE -> LOAD -> SHIFT_LO <-> SHIFT_HI -> LATCH -> ACK -> IDLE.
- IDLE: if only one req is high, grant it. If both are high, grant sel. If neither, stay. busy=0.
- LOAD (1 cycle): capture granted data into the shift register, set bit index to DATA_W-1, busy=1, grant updated.
- SHIFT_LO: shcp=0 and ds=current bit (MSB first) for CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI: shcp=1 for CLK_DIV cycles. If bit index is 0, go to LATCH; otherwise decrement the index and go to SHIFT_LO.
- LATCH: shcp=0, stcp=1 for CLK_DIV cycles. On exit, stcp=0 and oe=0. oe then stays 0 until reset.
- ACK (1 cycle): pulse ack of the granted requester, busy=0 on exit.
- Latency, defaults: req sampled at edge N gives LOAD at N+1, 2*DATA_W*CLK_DIV=128 shift cycles, 4 latch cycles. ack is high for exactly one cycle, 134 cycles after edge N.
- Data changing after LOAD has no effect on the frame in flight.
- req dropped mid-transfer: the transfer still completes and ack still pulses.
- A new req or a change of sel during a transfer is not evaluated until IDLE. The loser of a tie waits one full transfer plus one IDLE cycle.
- Back-to-back: a req held high after ack is re-granted from IDLE on the next cycle. Minimum gap between frames is 1 IDLE cycle.
- Reset mid-transfer: abort immediately to reset values. No ack; stcp is not pulsed, so the chain keeps its old latched content.
- Counters: divider is ceil(log2(CLK_DIV)) bits and wraps at CLK_DIV-1. Bit index is ceil(log2(DATA_W)) bits with no underflow.

Optional Feature:
DISP_ARB_ROUND_ROBIN_EN
- Defined: a tie is broken by granting the requester not served last (tracked by grant); sel is ignored.
- Undefined: a tie is always resolved to sel, and the non-selected requester can starve while sel's requester keeps requesting.

Decomposition:
- Shared package disp_pkg: FSM state encoding (IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, ACK), default DATA_W=16, default CLK_DIV=4.
- One natural sub-module, disp_div_tick: a CLK_DIV cycle counter with a synchronous clear and a terminal-count tick output. It is used by the SHIFT and LATCH phases.

Test Plan:
- Reset then idle, no req -> oe=1, shcp=stcp=ds=0, busy=0 for 50 cycles.
- req0 with data0=16'hA5C3 -> ds sampled at each shcp rise gives 1010_0101_1100_0011. One stcp pulse 4 cycles wide, then oe=0. ack0 pulses once, 134 cycles after the request edge; ack1 stays 0.
- req0 and req1 raised in the same cycle, sel=1 -> data1 shifted first and ack1 first. data0 follows after 1 IDLE cycle. With DISP_ARB_ROUND_ROBIN_EN and last grant=1, data0 goes first.
- data0 changed to 16'hFFFF at the cycle after LOAD -> the original frame is still shifted.
- rst driven low at the 60th shift cycle -> next edge all outputs at reset values, no stcp, no ack. Re-issuing req0 completes normally.
- req1 held high continuously -> frames repeat every 135 cycles, one ack1 pulse per frame.
